// File: rtl/gpio_wb_multi.sv
// gpio_wb_multi: configurable-width Wishbone GPIO bank with per-bit
// direction, output toggle, synchronised inputs and edge interrupts.
module gpio_wb_multi #(
    parameter int gpio_width  = 8,
    parameter int sync_stages = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic [gpio_width-1:0] gpio_i,
    output logic [gpio_width-1:0] gpio_o,
    output logic [gpio_width-1:0] gpio_oe,
    output logic                  irq
);

    localparam int W = gpio_width;

    logic [sync_stages-1:0][W-1:0] sync_q;
    logic [W-1:0] prev_q;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] dir_q, dir_d;
    logic [W-1:0] ie_q, ie_d;
    logic [W-1:0] rise_q, rise_d;
    logic [W-1:0] fall_q, fall_d;
    logic [W-1:0] pend_q, pend_d;
    logic         ack_q, ack_d;
    logic [31:0]  dat_q, dat_d;
    logic         irq_q, irq_d;

    logic         acc;
    logic         wr;
    logic [2:0]   reg_sel;
    logic [31:0]  lane_m;
    logic [W-1:0] wm;
    logic [W-1:0] wd;
    logic [W-1:0] in_w;
    logic [W-1:0] edges;
    logic [W-1:0] rd_w;
    logic [31:0]  rdata;
    logic         unused_ok;

    assign acc     = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr      = acc & wb_we_i;
    assign reg_sel = wb_adr_i[4:2];
    assign lane_m  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                      {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign wm      = lane_m[W-1:0];
    assign wd      = wb_dat_i[W-1:0] & wm;
    assign in_w    = sync_q[sync_stages-1];
    assign edges   = (in_w & ~prev_q & rise_q) |
                     (~in_w & prev_q & fall_q);

    assign unused_ok = ^{wb_adr_i[31:5], wb_adr_i[1:0],
                         wb_dat_i, lane_m};

    // Register write decode, W1C on PEND with edge set taking priority
    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        ie_d   = ie_q;
        rise_d = rise_q;
        fall_d = fall_q;
        pend_d = pend_q;
        if (wr) begin
            case (reg_sel)
                3'd1:    out_d  = (out_q & ~wm) | wd;
                3'd2:    dir_d  = (dir_q & ~wm) | wd;
                3'd3:    ie_d   = (ie_q & ~wm) | wd;
                3'd4:    rise_d = (rise_q & ~wm) | wd;
                3'd5:    fall_d = (fall_q & ~wm) | wd;
                3'd6:    pend_d = pend_q & ~wd;
                3'd7:    out_d  = out_q ^ wd;
                default: ;
            endcase
        end
        pend_d = pend_d | edges;
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        rd_w = '0;
        case (reg_sel)
            3'd0:    rd_w = in_w;
            3'd1:    rd_w = out_q;
            3'd2:    rd_w = dir_q;
            3'd3:    rd_w = ie_q;
            3'd4:    rd_w = rise_q;
            3'd5:    rd_w = fall_q;
            3'd6:    rd_w = pend_q;
            default: rd_w = '0;
        endcase
        rdata         = '0;
        rdata[W-1:0]  = rd_w;
    end

    // Bus response and interrupt next-state
    always_comb begin
        ack_d = acc;
        dat_d = acc ? rdata : 32'h0;
        irq_d = |(pend_q & ie_q);
    end

    // State registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
            out_q  <= '0;
            dir_q  <= '0;
            ie_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            pend_q <= '0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[sync_stages-2:0], gpio_i};
            prev_q <= in_w;
            out_q  <= out_d;
            dir_q  <= dir_d;
            ie_q   <= ie_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            pend_q <= pend_d;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            irq_q  <= irq_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign gpio_o   = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = irq_q;

endmodule

// File: doc/gpio_wb_multi.md
# gpio_wb_multi

Parametrised Wishbone GPIO peripheral for the LM32 system, replacing the fixed-width GPIO port with a configurable-width bank. It provides per-bit direction, atomic output toggle, metastability-safe input sampling, and per-bit rising/falling edge interrupt capture with a single combined interrupt line to the CPU. The block sits on the system Wishbone bus beside the UART. Pin tristating is done at the system top level from `gpio_o`/`gpio_oe`.

## Interface
- `gpio_width`, default 8: number of GPIO bits, legal range 1..32; register bits above `gpio_width` read 0 and ignore writes.
- `sync_stages`, default 2: input synchroniser depth, legal range 2..3.
- `clk` input 1: system clock; the only clock in the block.
- `rst` input 1: synchronous, active-high reset.
- `wb_cyc_i` input 1: Wishbone cycle.
- `wb_stb_i` input 1: Wishbone strobe.
- `wb_we_i` input 1: write enable.
- `wb_adr_i` input 32: byte address; only bits [4:2] are decoded.
- `wb_sel_i` input 4: byte lanes; writes honour each lane.
- `wb_dat_i` input 32: write data.
- `wb_dat_o` output 32: registered read data.
- `wb_ack_o` output 1: one-cycle acknowledge.
- `gpio_i` input gpio_width: asynchronous pin inputs.
- `gpio_o` output gpio_width: output values, equal to OUT.
- `gpio_oe` output gpio_width: output enables, equal to DIR (1 = drive).
- `irq` output 1: level interrupt, registered.

## Operation
- Register map (offset from `wb_adr_i[4:2]`):
  - 0x00 IN, read-only: last synchroniser stage.
  - 0x04 OUT, read/write.
  - 0x08 DIR, read/write.
  - 0x0C IE, read/write: interrupt enables.
  - 0x10 RISE, read/write: rising-edge capture enables.
  - 0x14 FALL, read/write: falling-edge capture enables.
  - 0x18 PEND, read / write-1-to-clear.
  - 0x1C TOGGLE, write-only: each 1 bit inverts the matching OUT bit; reads return 0.
- A write to IN has no effect.
- Byte-lane rule: write data bits in lane k apply only when `wb_sel_i[k]` = 1. This applies to TOGGLE and PEND as well.
- Synchroniser: `sync_stages` flops per bit. `prev` holds the final stage delayed one cycle.
- Edge detection: `rise = sync & ~prev & RISE`, `fall = ~sync & prev & FALL`. Each detected edge sets the matching PEND bit. PEND is set independently of IE.
- Interrupt: `irq` is registered from `|(PEND & IE)`.
- Simultaneous PEND set and W1C on the same bit in the same cycle: the set wins and the bit stays 1.
- Simultaneous TOGGLE writes cannot occur; the bus is single-master with one transaction at a time.
- Input bits whose DIR = 1 are still sampled and can still raise edges. This allows loopback.

## Timing
- Reset values: every register is 0, as are the sync chain, `prev`, `gpio_o`, `gpio_oe`, `irq`, `wb_ack_o` and `wb_dat_o`. All pins are therefore inputs after reset.
- Because RISE and FALL reset to 0, no PEND bit can be set by pin state at reset exit.
- Bus handshake:
  - Transaction accepted in the cycle where `wb_cyc_i & wb_stb_i & ~wb_ack_o`.
  - `wb_ack_o` rises on the next edge for exactly one cycle.
  - `wb_dat_o` is valid in that same cycle.
  - Register writes take effect on the same edge that raises ack.
  - If strobe stays high through ack, the next access is accepted in the cycle after ack falls. Peak throughput is one access per 2 cycles.
- Outputs: `gpio_o` and `gpio_oe` change on the write/ack edge. There is no additional latency.
- Input latency:
  - A pin change that meets setup before edge 0 appears in IN after `sync_stages` edges.
  - The matching PEND bit sets 1 edge after that, at `sync_stages+1`.
  - `irq` rises 1 edge after PEND, at `sync_stages+2`.
- Pulses shorter than one clock period may be missed. This is acceptable.
- `rst` asserted mid-transaction: the block returns to reset values on that edge. No ack is issued for the aborted access.

## Test plan
- Reset, then read all 8 offsets -> all read 0x00000000. `irq` = 0, `gpio_oe` = 0.
- `gpio_width`=8: write DIR=0xFF and OUT=0xA5, then TOGGLE=0x0F -> `gpio_oe`=0xFF, `gpio_o`=0xAA, OUT reads 0x000000AA. `wb_ack_o` is high exactly one cycle per access.
- Byte-lane write with `wb_sel_i`=0b0001 and data 0xFFFFFF3C to OUT (`gpio_width`=32, OUT=0x11223344) -> OUT reads 0x1122333C.
- RISE=0x01, IE=0x01, drive `gpio_i[0]` 0->1 (`sync_stages`=2) -> PEND[0]=1 at edge 3, `irq`=1 at edge 4. Write PEND=0x01 -> `irq`=0 one cycle after ack.
- FALL=0x02, IE=0: falling edge on bit 1 -> PEND reads 0x2 and `irq` stays 0. Then write IE=0x2 -> `irq`=1.
- Write PEND W1C on bit 0 in the same cycle a new rising edge is detected on bit 0 -> PEND[0] remains 1.
